pulse_deser: RTL and testbench

PULSE_DESER -- requirements
Module: pulse_deser

---
 rtl/pulse_deser.sv | 113 +++++++++++
 tb/tb_pulse_deser.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_deser.sv
// Serial-to-parallel word assembler behind a sequence detector: collects qualified
// bits MSB-first into WIDTH-bit words and presents them on a one-deep output register.
module pulse_deser #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             fsm_state
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic [WIDTH-1:0]   shifted;
    logic               word_done;

    assign shifted = {shreg_q[WIDTH-2:0], din};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // Collector: en=0 freezes everything; the WIDTH-th qualified bit completes the word.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        word_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = COLLECT;
                    cnt_d   = CNT_W'(1);
                    shreg_d = shifted;
                end
            end
            COLLECT: begin
                if (en) begin
                    shreg_d = shifted;
                    if (cnt_q == LAST_CNT) begin
                        word_done = 1'b1;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output register handshake: a word transfers on any edge with dout_valid=1 and
    // dout_ready=1; dout_ready is meaningless while dout_valid=0. A completing word
    // refills the register in the same edge it drains, otherwise it is dropped.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (word_done) begin
            if (!valid_q || dout_ready) begin
                dout_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign overrun    = ovr_q;
    assign bit_cnt    = cnt_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_pulse_deser.sv
// Bench for pulse_deser (WIDTH=8): directed table, multi-cycle corner sequences,
// and randomized traffic checked against a bit-queue reference model.
module tb_pulse_deser;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             din;
    logic             en;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;
    logic [CNT_W-1:0] bit_cnt;
    logic             fsm_state;

    pulse_deser #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .en         (en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .bit_cnt    (bit_cnt),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: bits of the partial word kept in arrival order
    int               m_bits[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_valid;
    logic             m_ovr;

    task automatic model_edge(input logic r, input logic e, input logic d, input logic rdy);
        int  word;
        bit  done;
        done = 0;
        word = 0;
        if (r) begin
            m_bits.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            if (e) begin
                m_bits.push_back(int'(d));
                if (m_bits.size() == WIDTH) begin
                    foreach (m_bits[k]) word = word * 2 + m_bits[k];
                    m_bits.delete();
                    done = 1;
                end
            end
            if (done) begin
                if (!m_valid || rdy) begin
                    m_dout  = WIDTH'(word);
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_model();
        check("dout",       int'(dout),       int'(m_dout));
        check("dout_valid", int'(dout_valid), int'(m_valid));
        check("overrun",    int'(overrun),    int'(m_ovr));
        check("bit_cnt",    int'(bit_cnt),    m_bits.size());
        check("fsm_state",  int'(fsm_state),  (m_bits.size() != 0) ? 1 : 0);
    endtask

    // driver: apply inputs for one edge, then sample #1 after it
    task automatic step(input logic r, input logic e, input logic d, input logic rdy);
        rst = r; en = e; din = d; dout_ready = rdy;
        @(posedge clk);
        #1;
        model_edge(r, e, d, rdy);
        check_model();
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic last_ready);
        for (int i = WIDTH - 1; i >= 0; i--)
            step(1'b0, 1'b1, w[i], (i == 0) ? last_ready : 1'b0);
    endtask

    typedef struct {
        logic       r, e, d, rdy;
        logic [7:0] x_dout;
        logic       x_valid, x_ovr;
        int         x_cnt;
    } vec_t;

    vec_t vecs[14];

    initial begin
        rst = 1'b1; en = 1'b0; din = 1'b0; dout_ready = 1'b0;
        m_dout = '0; m_valid = 1'b0; m_ovr = 1'b0;

        // basic assembly of 0xB2, hold, drain, ready ignored while empty
        vecs[0]  = '{1, 0, 0, 0, 8'h00, 0, 0, 0};
        vecs[1]  = '{1, 1, 1, 1, 8'h00, 0, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 8'h00, 0, 0, 0};
        vecs[3]  = '{0, 1, 1, 0, 8'h00, 0, 0, 1};
        vecs[4]  = '{0, 1, 0, 0, 8'h00, 0, 0, 2};
        vecs[5]  = '{0, 1, 1, 0, 8'h00, 0, 0, 3};
        vecs[6]  = '{0, 1, 1, 0, 8'h00, 0, 0, 4};
        vecs[7]  = '{0, 1, 0, 0, 8'h00, 0, 0, 5};
        vecs[8]  = '{0, 1, 0, 0, 8'h00, 0, 0, 6};
        vecs[9]  = '{0, 1, 1, 0, 8'h00, 0, 0, 7};
        vecs[10] = '{0, 1, 0, 0, 8'hB2, 1, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 8'hB2, 1, 0, 0};
        vecs[12] = '{0, 0, 1, 1, 8'hB2, 0, 0, 0};
        vecs[13] = '{0, 0, 0, 1, 8'hB2, 0, 0, 0};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].r, vecs[i].e, vecs[i].d, vecs[i].rdy);
            check($sformatf("vec%0d_dout", i),  int'(dout),       int'(vecs[i].x_dout));
            check($sformatf("vec%0d_valid", i), int'(dout_valid), int'(vecs[i].x_valid));
            check($sformatf("vec%0d_ovr", i),   int'(overrun),    int'(vecs[i].x_ovr));
            check($sformatf("vec%0d_cnt", i),   int'(bit_cnt),    vecs[i].x_cnt);
        end

        // gapped input: bit_cnt holds at 3 through two unqualified cycles
        step(1, 0, 0, 0);
        step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 1, 0);
        step(0, 0, 0, 0); check("gap_cnt_a", int'(bit_cnt), 3);
        step(0, 0, 1, 0); check("gap_cnt_b", int'(bit_cnt), 3);
        step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 1, 0); step(0, 1, 0, 0);
        check("gap_dout", int'(dout), 'hB2);
        check("gap_valid", int'(dout_valid), 1);

        // back-to-back words, handshake on the completing edge
        step(1, 0, 0, 0);
        send_word(8'hB2, 1'b0);
        send_word(8'h0F, 1'b1);
        check("b2b_dout", int'(dout), 'h0F);
        check("b2b_valid", int'(dout_valid), 1);
        check("b2b_ovr", int'(overrun), 0);

        // overrun: second word dropped, flag sticky across a handshake
        step(1, 0, 0, 0);
        send_word(8'hB2, 1'b0);
        send_word(8'hFF, 1'b0);
        check("ovr_dout", int'(dout), 'hB2);
        check("ovr_flag", int'(overrun), 1);
        step(0, 0, 0, 1);
        check("ovr_sticky", int'(overrun), 1);
        check("ovr_drained", int'(dout_valid), 0);

        // reset mid-word discards partial bits and clears overrun
        for (int i = 0; i < 5; i++) step(0, 1, 1'(i & 1), 0);
        check("mid_cnt5", int'(bit_cnt), 5);
        step(1, 1, 1, 1);
        check("rst_cnt", int'(bit_cnt), 0);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_ovr", int'(overrun), 0);
        send_word(8'h5A, 1'b0);
        check("rst_dout", int'(dout), 'h5A);
        check("rst_valid2", int'(dout_valid), 1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
